rope_collision_manager: RTL and testbench

//  Receiving end of the rope display bank: consumes per-rope drawing requests and speeds, detects

---
 rtl/rope_collision_manager.sv | 130 +++++++++++++
 tb/tb_rope_collision_manager.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rope_collision_manager.sv
// Rope/border and rope/monkey overlap detection per frame, with a grab FSM for the monkey.
// Optional build macro ROPE_TOGGLE_HOLDOFF_EN masks repeat border toggles per rope.
module rope_collision_manager #(
    parameter int ROPES           = 6,
    parameter int IDX_W           = 3,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic [ROPES-1:0]       ropeDR,
    input  logic                   monkeyDR,
    input  logic                   borderDR,
    input  logic [ROPES-1:0][31:0] ropeSpeeds,
    input  logic                   releaseKey,
    output logic [ROPES-1:0]       dirToggle,
    output logic [ROPES-1:0]       monkeyCollision,
    output logic                   holding,
    output logic [IDX_W-1:0]       grabbedRope,
    output logic [31:0]            monkeySpeedX
);

    typedef enum logic [1:0] {FREE, HOLD, COOLDOWN} state_t;

    state_t           state, state_n;
    logic [ROPES-1:0] acc_m, acc_b, snap_m, snap_b, toggle_n;
    logic [7:0]       cool, cool_n;
    logic [IDX_W-1:0] grab_n, low_idx;
    logic [31:0]      speed_n;
    logic             any_hit;

    // Snapshot includes the overlap seen on the startOfFrame cycle itself
    assign snap_m  = acc_m | (ropeDR & {ROPES{monkeyDR}});
    assign snap_b  = acc_b | (ropeDR & {ROPES{borderDR}});
    assign any_hit = |snap_m;
    assign holding = (state == HOLD);

`ifdef ROPE_TOGGLE_HOLDOFF_EN
    logic [ROPES-1:0][1:0] holdoff;

    always_comb begin
        toggle_n = '0;
        for (int i = 0; i < ROPES; i++)
            toggle_n[i] = snap_b[i] && (holdoff[i] == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdoff <= '0;
        end else if (startOfFrame) begin
            for (int i = 0; i < ROPES; i++) begin
                if (toggle_n[i])
                    holdoff[i] <= 2'd2;
                else if (holdoff[i] != 2'd0)
                    holdoff[i] <= holdoff[i] - 2'd1;
            end
        end
    end
`else
    assign toggle_n = snap_b;
`endif

    always_comb begin
        low_idx = '0;
        for (int i = ROPES - 1; i >= 0; i--)
            if (snap_m[i]) low_idx = IDX_W'(i);
    end

    always_comb begin
        state_n = state;
        cool_n  = cool;
        grab_n  = grabbedRope;
        speed_n = monkeySpeedX;
        if (startOfFrame) begin
            unique case (state)
                FREE: begin
                    if (any_hit) begin
                        state_n = HOLD;
                        grab_n  = low_idx;
                        speed_n = ropeSpeeds[low_idx];
                    end
                end
                HOLD: begin
                    if (releaseKey || !snap_m[grabbedRope]) begin
                        state_n = COOLDOWN;
                        cool_n  = 8'(COOLDOWN_FRAMES);
                        grab_n  = '0;
                        speed_n = '0;
                    end else begin
                        speed_n = ropeSpeeds[grabbedRope];
                    end
                end
                COOLDOWN: begin
                    if (cool != 8'd0) cool_n = cool - 8'd1;
                    if (cool <= 8'd1) state_n = FREE;
                end
                default: state_n = FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= FREE;
            cool            <= '0;
            grabbedRope     <= '0;
            monkeySpeedX    <= '0;
            acc_m           <= '0;
            acc_b           <= '0;
            dirToggle       <= '0;
            monkeyCollision <= '0;
        end else begin
            state        <= state_n;
            cool         <= cool_n;
            grabbedRope  <= grab_n;
            monkeySpeedX <= speed_n;
            if (startOfFrame) begin
                acc_m           <= '0;
                acc_b           <= '0;
                dirToggle       <= toggle_n;
                monkeyCollision <= snap_m;
            end else begin
                acc_m     <= snap_m;
                acc_b     <= snap_b;
                dirToggle <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rope_collision_manager.sv
// Bench for rope_collision_manager: vector table, corner sequences, random vs model.
// Honors ROPE_TOGGLE_HOLDOFF_EN the same way as the design build.
module tb_rope_collision_manager;

    localparam int ROPES = 6;
    localparam int IDX_W = 3;
    localparam int CD    = 8;

    logic                   clk = 1'b0;
    logic                   reset, startOfFrame, monkeyDR, borderDR, releaseKey;
    logic [ROPES-1:0]       ropeDR, dirToggle, monkeyCollision;
    logic [ROPES-1:0][31:0] ropeSpeeds;
    logic                   holding;
    logic [IDX_W-1:0]       grabbedRope;
    logic [31:0]            monkeySpeedX;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rope_collision_manager #(.ROPES(ROPES), .IDX_W(IDX_W), .COOLDOWN_FRAMES(CD)) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .ropeDR(ropeDR), .monkeyDR(monkeyDR), .borderDR(borderDR),
        .ropeSpeeds(ropeSpeeds), .releaseKey(releaseKey),
        .dirToggle(dirToggle), .monkeyCollision(monkeyCollision),
        .holding(holding), .grabbedRope(grabbedRope), .monkeySpeedX(monkeySpeedX)
    );

    typedef struct {
        logic [5:0]  rope;
        logic        mk, bd, sof, rel;
        logic [5:0]  dt, mc;
        logic        hold;
        logic [2:0]  g;
        logic [31:0] spd;
    } vec_t;

    // Reference model: overlap pixel counts per rope, snapshot/frame bookkeeping
    int          m_cm[ROPES];
    int          m_cb[ROPES];
    int          m_last[ROPES];
    int          m_frame, m_st, m_g, m_relf;
    logic [31:0] m_spd;
    logic [5:0]  e_dt, e_mc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        ropeDR = '0; monkeyDR = 1'b0; borderDR = 1'b0;
        startOfFrame = 1'b0; releaseKey = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic void m_reset();
        for (int i = 0; i < ROPES; i++) begin
            m_cm[i] = 0; m_cb[i] = 0; m_last[i] = -100;
        end
        m_frame = 0; m_st = 0; m_g = 0; m_relf = 0;
        m_spd = '0; e_dt = '0; e_mc = '0;
    endfunction

    function automatic void m_clock();
        logic hb;
        int   first;
        for (int i = 0; i < ROPES; i++) begin
            if (ropeDR[i] && monkeyDR) m_cm[i]++;
            if (ropeDR[i] && borderDR) m_cb[i]++;
        end
        e_dt = '0;
        if (startOfFrame) begin
            m_frame++;
            for (int i = 0; i < ROPES; i++) begin
                e_mc[i] = (m_cm[i] > 0);
                hb = (m_cb[i] > 0);
`ifdef ROPE_TOGGLE_HOLDOFF_EN
                if (hb && (m_frame - m_last[i] > 2)) begin
                    e_dt[i] = 1'b1;
                    m_last[i] = m_frame;
                end
`else
                e_dt[i] = hb;
`endif
            end
            if (m_st == 0) begin
                first = -1;
                for (int i = ROPES - 1; i >= 0; i--) if (e_mc[i]) first = i;
                if (first >= 0) begin
                    m_st = 1; m_g = first; m_spd = ropeSpeeds[first];
                end
            end else if (m_st == 1) begin
                if (releaseKey || !e_mc[m_g]) begin
                    m_st = 2; m_g = 0; m_spd = '0; m_relf = m_frame;
                end else begin
                    m_spd = ropeSpeeds[m_g];
                end
            end else if (m_frame - m_relf >= CD) begin
                m_st = 0;
            end
            for (int i = 0; i < ROPES; i++) begin
                m_cm[i] = 0; m_cb[i] = 0;
            end
        end
    endfunction

    task automatic check_model();
        chk("rand.dirToggle", 32'(dirToggle), 32'(e_dt));
        chk("rand.monkeyCollision", 32'(monkeyCollision), 32'(e_mc));
        chk("rand.holding", 32'(holding), 32'(m_st == 1));
        chk("rand.grabbedRope", 32'(grabbedRope), 32'(m_g));
        chk("rand.monkeySpeedX", monkeySpeedX, m_spd);
        chk("rand.idx_range", 32'(int'(grabbedRope) < ROPES), 32'd1);
    endtask

    initial begin
        vec_t tbl[10];
        int   pulses;
        int   exp_pulses;

        reset = 1'b1;
        idle();
        for (int i = 0; i < ROPES; i++) ropeSpeeds[i] = 32'(i * 100 + 5);
        ropeSpeeds[1] = -32'sd20;
        #3;
        chk("reset.dirToggle", 32'(dirToggle), 32'd0);
        chk("reset.monkeyCollision", 32'(monkeyCollision), 32'd0);
        chk("reset.holding", 32'(holding), 32'd0);
        chk("reset.monkeySpeedX", monkeySpeedX, 32'd0);
        do_reset();

        // rope mk bd sof rel | dt mc hold g spd
        tbl[0] = '{6'h04, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 32'h0};
        tbl[1] = '{6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h04, 6'h00, 1'b0, 3'd0, 32'h0};
        tbl[2] = '{6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 32'h0};
        tbl[3] = '{6'h12, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 32'h0};
        tbl[4] = '{6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 6'h12, 1'b1, 3'd1, 32'hFFFFFFEC};
        tbl[5] = '{6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h12, 1'b1, 3'd1, 32'hFFFFFFEC};
        tbl[6] = '{6'h02, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 6'h02, 1'b1, 3'd1, 32'hFFFFFFEC};
        tbl[7] = '{6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h02, 1'b1, 3'd1, 32'hFFFFFFEC};
        tbl[8] = '{6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 3'd0, 32'h0};
        tbl[9] = '{6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 3'd0, 32'h0};

        for (int v = 0; v < 10; v++) begin
            ropeDR = tbl[v].rope; monkeyDR = tbl[v].mk; borderDR = tbl[v].bd;
            startOfFrame = tbl[v].sof; releaseKey = tbl[v].rel;
            step();
            chk($sformatf("vec%0d.dirToggle", v), 32'(dirToggle), 32'(tbl[v].dt));
            chk($sformatf("vec%0d.monkeyCollision", v), 32'(monkeyCollision), 32'(tbl[v].mc));
            chk($sformatf("vec%0d.holding", v), 32'(holding), 32'(tbl[v].hold));
            chk($sformatf("vec%0d.grabbedRope", v), 32'(grabbedRope), 32'(tbl[v].g));
            chk($sformatf("vec%0d.monkeySpeedX", v), monkeySpeedX, tbl[v].spd);
        end

        // Reset mid-frame discards accumulated overlap
        idle();
        do_reset();
        ropeDR = 6'h3F; monkeyDR = 1'b1; borderDR = 1'b1;
        step();
        startOfFrame = 1'b1;
        step();
        chk("midrst.pre_mc", 32'(monkeyCollision), 32'h3F);
        chk("midrst.pre_speed", monkeySpeedX, 32'd5);
        startOfFrame = 1'b0;
        step();
        #2 reset = 1'b1;
        #1;
        chk("midrst.mc", 32'(monkeyCollision), 32'd0);
        chk("midrst.holding", 32'(holding), 32'd0);
        chk("midrst.speed", monkeySpeedX, 32'd0);
        chk("midrst.dt", 32'(dirToggle), 32'd0);
        reset = 1'b0;
        idle();
        step();
        startOfFrame = 1'b1;
        step();
        chk("midrst.sof_dt", 32'(dirToggle), 32'd0);
        chk("midrst.sof_mc", 32'(monkeyCollision), 32'd0);
        chk("midrst.sof_hold", 32'(holding), 32'd0);

        // Release then cooldown: regrab only on the 9th snapshot
        idle();
        do_reset();
        ropeDR = 6'h02; monkeyDR = 1'b1;
        startOfFrame = 1'b1;
        step();
        chk("cool.grab", 32'(holding), 32'd1);
        releaseKey = 1'b1;
        step();
        chk("cool.release_hold", 32'(holding), 32'd0);
        chk("cool.release_speed", monkeySpeedX, 32'd0);
        releaseKey = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            startOfFrame = 1'b0;
            step();
            startOfFrame = 1'b1;
            step();
            chk($sformatf("cool.sof%0d.hold", k), 32'(holding), 32'(k == 9));
            chk($sformatf("cool.sof%0d.speed", k), monkeySpeedX, (k == 9) ? 32'hFFFFFFEC : 32'd0);
        end

        // Rope 0 on the border for three consecutive frames
        idle();
        do_reset();
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            ropeDR = 6'h01; borderDR = 1'b1; startOfFrame = 1'b0;
            step();
            startOfFrame = 1'b1;
            step();
            if (dirToggle[0]) pulses++;
            startOfFrame = 1'b0;
            step();
            chk($sformatf("border.f%0d.one_cycle", f), 32'(dirToggle), 32'd0);
        end
`ifdef ROPE_TOGGLE_HOLDOFF_EN
        exp_pulses = 1;
`else
        exp_pulses = 3;
`endif
        chk("border.pulses", 32'(pulses), 32'(exp_pulses));

        // Randomized run against the reference model
        idle();
        do_reset();
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = 1'b0;
            ropeSpeeds[$urandom_range(0, ROPES - 1)] = $urandom;
            ropeDR       = 6'($urandom & $urandom);
            monkeyDR     = 1'($urandom_range(0, 1));
            borderDR     = ($urandom_range(0, 3) == 0);
            startOfFrame = ($urandom_range(0, 11) == 0);
            releaseKey   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                m_reset();
            end else begin
                m_clock();
            end
            step();
            check_model();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
